// File: rtl/weight_ram_sched_h1_pkg.sv
// Shared types, sizes and the saturating weight adder for the
// hidden-layer-1 weight RAM scheduler.
package weight_ram_sched_h1_pkg;

  localparam int W  = 24;       // weight width (signed)
  localparam int AW = 10;       // RAM address width
  localparam int CW = 16;       // committed-write counter width
  localparam int SW = 4;        // starvation counter width

  localparam int WMAX = 65536;  // 16 * 4096
  localparam int WMIN = -65536;

  // Consecutive denied update cycles before the update wins over inference.
  localparam logic [SW-1:0] STARVE = 4'd8;

  // Clamp bounds expressed at the W+1 bit width of the raw sum.
  localparam logic signed [W:0] SUM_MAX = WMAX[W:0];
  localparam logic signed [W:0] SUM_MIN = WMIN[W:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Sign-extend both operands to W+1 bits, add, and clamp to [WMIN, WMAX].
  // The extra bit means the sum itself can never wrap.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [W:0] sum;
    sum = $signed({a[W-1], a}) + $signed({b[W-1], b});
    if (sum > SUM_MAX) begin
      return SUM_MAX[W-1:0];
    end else if (sum < SUM_MIN) begin
      return SUM_MIN[W-1:0];
    end else begin
      return sum[W-1:0];
    end
  endfunction

endpackage

// File: rtl/weight_ram_sched_h1_if.sv
// Requester-side bus of the weight RAM scheduler: the inference read
// channel and the STDP update channel.
interface weight_ram_sched_h1_if;
  import weight_ram_sched_h1_pkg::*;

  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [W-1:0]  rd_data;

  logic          upd_req;
  logic [AW-1:0] upd_addr;
  logic [W-1:0]  upd_delta;
  logic          upd_gnt;

  // Requesters (inference datapath and learning unit).
  modport master (
    output rd_req, rd_addr, upd_req, upd_addr, upd_delta,
    input  rd_gnt, rd_valid, rd_data, upd_gnt
  );

  // Scheduler.
  modport slave (
    input  rd_req, rd_addr, upd_req, upd_addr, upd_delta,
    output rd_gnt, rd_valid, rd_data, upd_gnt
  );
endinterface

// File: rtl/weight_ram_sched_h1_wt_rmw_pipe.sv
// Read-modify-write pipeline for weight updates. Stage 1 holds the
// granted address/delta while the RAM read is in flight; stage 2 holds the
// clamped result and drives the RAM write port. Both stage addresses are
// compared against the incoming requests to block read-after-write hazards.
module wt_rmw_pipe
  import weight_ram_sched_h1_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          upd_gnt,
  input  logic [AW-1:0] upd_addr,
  input  logic [W-1:0]  upd_delta,
  input  logic [W-1:0]  ram_data_r,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_haz,
  output logic          upd_haz,
  output logic          empty,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [W-1:0]  wdata
);

  logic          s1_v_r;
  logic [AW-1:0] s1_addr_r;
  logic [W-1:0]  s1_delta_r;
  logic          s2_v_r;
  logic [AW-1:0] s2_addr_r;
  logic [W-1:0]  s2_data_r;

  // Advance the two RMW stages; stage 2 adds the RAM word read for stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_r     <= 1'b0;
      s1_addr_r  <= '0;
      s1_delta_r <= '0;
      s2_v_r     <= 1'b0;
      s2_addr_r  <= '0;
      s2_data_r  <= '0;
    end else begin
      s1_v_r <= upd_gnt;
      if (upd_gnt) begin
        s1_addr_r  <= upd_addr;
        s1_delta_r <= upd_delta;
      end
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        s2_addr_r <= s1_addr_r;
        s2_data_r <= sat_add(ram_data_r, s1_delta_r);
      end
    end
  end

  // Any address still being read-modified-written must not be touched.
  assign rd_haz  = (s1_v_r && (s1_addr_r == rd_addr))  ||
                   (s2_v_r && (s2_addr_r == rd_addr));
  assign upd_haz = (s1_v_r && (s1_addr_r == upd_addr)) ||
                   (s2_v_r && (s2_addr_r == upd_addr));

  assign empty = !s1_v_r && !s2_v_r;
  assign we    = s2_v_r;
  assign waddr = s2_addr_r;
  assign wdata = s2_data_r;

endmodule

// File: rtl/weight_ram_sched_h1.sv
// Arbiter and sequencer for the hidden-layer-1 weight RAM. Shares the single
// read port between inference reads and STDP read-modify-write updates,
// prevents starvation of updates, and drains in-flight updates on flush.
module weight_ram_sched_h1
  import weight_ram_sched_h1_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_core_img,
  input  logic                       flush,
  output logic                       flush_done,
  output logic                       busy,
  weight_ram_sched_h1_if.slave       bus,
  output logic [CW-1:0]              upd_count,
  output logic [AW-1:0]              ram_addr_r,
  input  logic [W-1:0]               ram_data_r,
  output logic                       ram_we,
  output logic [AW-1:0]              ram_addr_w,
  output logic [W-1:0]               ram_data_w
);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [SW-1:0] starve_cnt_r;
  logic [AW-1:0] last_addr_r;
  logic          rd_valid_r;
  logic          idle_flush_r;
  logic [CW-1:0] upd_count_r;
  logic          drain_done_s;
  logic          rd_gnt_s;
  logic          upd_gnt_s;
  logic          rd_haz_s;
  logic          upd_haz_s;
  logic          pipe_empty_s;

  wt_rmw_pipe u_pipe (
    .clk        (clk),
    .rst        (rst),
    .upd_gnt    (upd_gnt_s),
    .upd_addr   (bus.upd_addr),
    .upd_delta  (bus.upd_delta),
    .ram_data_r (ram_data_r),
    .rd_addr    (bus.rd_addr),
    .rd_haz     (rd_haz_s),
    .upd_haz    (upd_haz_s),
    .empty      (pipe_empty_s),
    .we         (ram_we),
    .waddr      (ram_addr_w),
    .wdata      (ram_data_w)
  );

  // FSM next state; a drain completes as soon as both RMW stages are empty.
  always_comb begin
    state_nxt_s  = state_r;
    drain_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_core_img) begin
          state_nxt_s = ACTIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (flush) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = ACTIVE;
        end
      end
      DRAIN: begin
        if (pipe_empty_s) begin
          drain_done_s = 1'b1;
          state_nxt_s  = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Single grant per cycle: inference first unless the update has starved;
  // a hazard-blocked update cannot claim its priority.
  always_comb begin
    rd_gnt_s  = 1'b0;
    upd_gnt_s = 1'b0;
    if (state_r == ACTIVE) begin
      if ((starve_cnt_r == STARVE) && bus.upd_req && !upd_haz_s) begin
        upd_gnt_s = 1'b1;
      end else if (bus.rd_req && !rd_haz_s) begin
        rd_gnt_s = 1'b1;
      end else if (bus.upd_req && !upd_haz_s) begin
        upd_gnt_s = 1'b1;
      end else begin
        rd_gnt_s  = 1'b0;
        upd_gnt_s = 1'b0;
      end
    end else begin
      rd_gnt_s  = 1'b0;
      upd_gnt_s = 1'b0;
    end
  end

  // Read address follows the granted requester so RAM data lands next cycle.
  always_comb begin
    ram_addr_r = last_addr_r;
    if (rd_gnt_s) begin
      ram_addr_r = bus.rd_addr;
    end else if (upd_gnt_s) begin
      ram_addr_r = bus.upd_addr;
    end else begin
      ram_addr_r = last_addr_r;
    end
  end

  // State, read-valid, address hold and idle-flush acknowledge registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_addr_r  <= '0;
      rd_valid_r   <= 1'b0;
      idle_flush_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      last_addr_r  <= ram_addr_r;
      rd_valid_r   <= rd_gnt_s;
      idle_flush_r <= (state_r == IDLE) && flush;
    end
  end

  // Starvation counter: counts denied update cycles while arbitrating.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= '0;
    end else if (upd_gnt_s || (state_r != ACTIVE)) begin
      starve_cnt_r <= '0;
    end else if (bus.upd_req && (starve_cnt_r != STARVE)) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end
  end

  // Committed-write counter, cleared when a new image starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_count_r <= '0;
    end else if ((state_r == IDLE) && start_core_img) begin
      upd_count_r <= '0;
    end else if (ram_we && (upd_count_r != 16'hFFFF)) begin
      upd_count_r <= upd_count_r + 16'd1;
    end
  end

  assign bus.rd_gnt   = rd_gnt_s;
  assign bus.upd_gnt  = upd_gnt_s;
  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_data  = rd_valid_r ? ram_data_r : '0;
  assign upd_count    = upd_count_r;
  assign busy         = (state_r != IDLE);
  assign flush_done   = drain_done_s || idle_flush_r;

endmodule

// File: tb/tb_weight_ram_sched_h1.sv
// Self-checking bench for weight_ram_sched_h1 with a behavioural weight RAM
// and read/write scoreboards fed from a shadow copy of the RAM contents.
module tb_weight_ram_sched_h1;
  import weight_ram_sched_h1_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_core_img;
  logic          flush;
  logic          flush_done;
  logic          busy;
  logic [15:0]   upd_count;
  logic [AW-1:0] ram_addr_r;
  logic [W-1:0]  ram_data_r;
  logic          ram_we;
  logic [AW-1:0] ram_addr_w;
  logic [W-1:0]  ram_data_w;

  weight_ram_sched_h1_if bus();

  weight_ram_sched_h1 dut (
    .clk            (clk),
    .rst            (rst),
    .start_core_img (start_core_img),
    .flush          (flush),
    .flush_done     (flush_done),
    .busy           (busy),
    .bus            (bus),
    .upd_count      (upd_count),
    .ram_addr_r     (ram_addr_r),
    .ram_data_r     (ram_data_r),
    .ram_we         (ram_we),
    .ram_addr_w     (ram_addr_w),
    .ram_data_w     (ram_data_w)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: registered read, write port, plus a bench preload port.
  logic [W-1:0]  mem [0:1023];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [W-1:0]  pre_data;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_w] <= ram_data_w;
    else if (pre_we) mem[pre_addr] <= pre_data;
    ram_data_r <= mem[ram_addr_r];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  logic [W-1:0]    model [0:1023];
  logic [W-1:0]    exp_rd[$];
  logic [AW+W-1:0] exp_wr[$];

  logic s_rd_gnt, s_upd_gnt, s_rd_valid, s_we, s_fd, s_busy;
  logic [W-1:0]  s_rd_data, s_data_w;
  logic [AW-1:0] s_addr_r, s_addr_w;
  logic [15:0]   s_cnt;

  function automatic logic [W-1:0] ref_clamp(input logic [W-1:0] old, input int d);
    int s;
    s = int'($signed(old)) + d;
    if (s > 65536) s = 65536;
    if (s < -65536) s = -65536;
    return s[W-1:0];
  endfunction

  // One clock cycle: sample outputs mid-cycle, retire scoreboard entries.
  task automatic step();
    logic [W-1:0]    e;
    logic [AW+W-1:0] ew;
    @(negedge clk);
    s_rd_gnt = bus.rd_gnt;   s_upd_gnt = bus.upd_gnt;
    s_rd_valid = bus.rd_valid; s_rd_data = bus.rd_data;
    s_we = ram_we; s_addr_w = ram_addr_w; s_data_w = ram_data_w;
    s_fd = flush_done; s_busy = busy; s_cnt = upd_count; s_addr_r = ram_addr_r;
    if (bus.rd_valid === 1'b1) begin
      n_tests++;
      if (exp_rd.size() == 0) begin
        n_fail++; $display("FAIL rd_data: unexpected read data %0h", bus.rd_data);
      end else begin
        e = exp_rd.pop_front();
        if (bus.rd_data !== e) begin
          n_fail++; $display("FAIL rd_data: got %0h want %0h", bus.rd_data, e);
        end
      end
    end
    if (ram_we === 1'b1) begin
      n_tests++;
      if (exp_wr.size() == 0) begin
        n_fail++; $display("FAIL ram_write: unexpected write addr %0d data %0h", ram_addr_w, ram_data_w);
      end else begin
        ew = exp_wr.pop_front();
        if ({ram_addr_w, ram_data_w} !== ew) begin
          n_fail++; $display("FAIL ram_write: got addr %0d data %0h want addr %0d data %0h",
                             ram_addr_w, ram_data_w, ew[AW+W-1:W], ew[W-1:0]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic poke(input int a, input int d);
    pre_we = 1'b1; pre_addr = a[AW-1:0]; pre_data = d[W-1:0];
    model[a] = d[W-1:0];
    step();
    pre_we = 1'b0;
  endtask

  // Drive an update request and push the write it must eventually produce.
  task automatic issue_upd(input int a, input int d);
    bus.upd_req = 1'b1; bus.upd_addr = a[AW-1:0]; bus.upd_delta = d[W-1:0];
    model[a] = ref_clamp(model[a], d);
    exp_wr.push_back({a[AW-1:0], model[a]});
    exp_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    n_tests++;
    if ({s_rd_gnt, s_upd_gnt, s_rd_valid, s_we, s_fd, s_busy} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {s_rd_gnt, s_upd_gnt, s_rd_valid, s_we, s_fd, s_busy});
    end
    n_tests++;
    if (s_rd_data !== '0 || s_addr_r !== '0 || s_addr_w !== '0 || s_data_w !== '0 || s_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_data: got %0h %0h %0h %0h %0h want all 0", s_rd_data, s_addr_r, s_addr_w, s_data_w, s_cnt);
    end
  endtask

  task automatic test_read();
    poke(5, 100);
    start_core_img = 1'b1; step(); start_core_img = 1'b0; exp_cnt = 0;
    bus.rd_req = 1'b1; bus.rd_addr = 10'd5; exp_rd.push_back(model[5]);
    step();
    n_tests++;
    if (s_rd_gnt !== 1'b1 || s_busy !== 1'b1 || s_addr_r !== 10'd5 || s_rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL read_grant: got gnt %b busy %b addr %0d vld %b want 1 1 5 0", s_rd_gnt, s_busy, s_addr_r, s_rd_valid);
    end
    bus.rd_req = 1'b0; step();
    n_tests++;
    if (s_rd_valid !== 1'b1 || s_addr_r !== 10'd5) begin
      n_fail++; $display("FAIL read_valid: got vld %b addr %0d want 1 5", s_rd_valid, s_addr_r);
    end
    step();
    n_tests++;
    if (s_rd_valid !== 1'b0 || s_rd_data !== '0) begin
      n_fail++; $display("FAIL read_idle: got vld %b data %0h want 0 0", s_rd_valid, s_rd_data);
    end
  endtask

  task automatic test_update();
    poke(7, 1000);
    issue_upd(7, -24); step();
    n_tests++;
    if (s_upd_gnt !== 1'b1 || s_rd_gnt !== 1'b0) begin
      n_fail++; $display("FAIL upd_grant: got upd %b rd %b want 1 0", s_upd_gnt, s_rd_gnt);
    end
    bus.upd_req = 1'b0; step();
    n_tests++;
    if (s_we !== 1'b0) begin n_fail++; $display("FAIL upd_we_early: got %b want 0", s_we); end
    step();
    n_tests++;
    if (s_we !== 1'b1 || s_addr_w !== 10'd7 || s_data_w !== 24'd976) begin
      n_fail++; $display("FAIL upd_write: got we %b addr %0d data %0d want 1 7 976", s_we, s_addr_w, s_data_w);
    end
    step();
    n_tests++;
    if (s_cnt !== 16'd1) begin n_fail++; $display("FAIL upd_count: got %0d want 1", s_cnt); end
  endtask

  task automatic test_saturation();
    poke(3, 65000); poke(4, -65000);
    issue_upd(3, 2000); step();
    n_tests++;
    if (s_upd_gnt !== 1'b1) begin n_fail++; $display("FAIL sat_grant0: got %b want 1", s_upd_gnt); end
    issue_upd(4, -2000); step();
    n_tests++;
    if (s_upd_gnt !== 1'b1) begin n_fail++; $display("FAIL sat_grant1: got %b want 1", s_upd_gnt); end
    bus.upd_req = 1'b0; step();
    n_tests++;
    if (s_we !== 1'b1 || s_data_w !== 24'h010000) begin
      n_fail++; $display("FAIL sat_max: got we %b data %0h want 1 10000", s_we, s_data_w);
    end
    step();
    n_tests++;
    if (s_we !== 1'b1 || s_data_w !== 24'hFF0000) begin
      n_fail++; $display("FAIL sat_min: got we %b data %0h want 1 ff0000", s_we, s_data_w);
    end
    step();
    n_tests++;
    if (s_cnt !== exp_cnt[15:0]) begin n_fail++; $display("FAIL sat_count: got %0d want %0d", s_cnt, exp_cnt); end
  endtask

  task automatic test_hazard();
    poke(9, 500);
    issue_upd(9, 11); step();
    n_tests++;
    if (s_upd_gnt !== 1'b1) begin n_fail++; $display("FAIL haz_upd_grant: got %b want 1", s_upd_gnt); end
    bus.upd_req = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 10'd9; exp_rd.push_back(model[9]);
    for (int c = 1; c <= 3; c++) begin
      step();
      n_tests++;
      if (s_rd_gnt !== (c == 3)) begin
        n_fail++; $display("FAIL haz_rd_grant T+%0d: got %b want %b", c, s_rd_gnt, (c == 3));
      end
      if (c == 3) bus.rd_req = 1'b0;
    end
    step();
    n_tests++;
    if (exp_rd.size() != 0) begin n_fail++; $display("FAIL haz_read_return: got %0d pending want 0", exp_rd.size()); end
  endtask

  task automatic test_starvation();
    poke(30, 77); poke(20, 0);
    for (int i = 1; i <= 12; i++) begin
      bus.rd_req = 1'b1; bus.rd_addr = 10'd30;
      if (i == 1) issue_upd(20, 1);
      if (i > 9) bus.upd_req = 1'b0;
      if (i != 9) exp_rd.push_back(model[30]);
      step();
      n_tests++;
      if ({s_rd_gnt, s_upd_gnt} !== ((i == 9) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL starve_cycle%0d: got rd/upd %b want %b", i, {s_rd_gnt, s_upd_gnt}, ((i == 9) ? 2'b01 : 2'b10));
      end
    end
    bus.rd_req = 1'b0; bus.upd_req = 1'b0;
    repeat (4) step();
    n_tests++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      n_fail++; $display("FAIL starve_drain: got %0d/%0d pending want 0/0", exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_flush();
    poke(40, 10); poke(41, 20);
    issue_upd(40, 5); step();
    issue_upd(41, -5); step();
    n_tests++;
    if (s_upd_gnt !== 1'b1) begin n_fail++; $display("FAIL flush_grant: got %b want 1", s_upd_gnt); end
    bus.upd_req = 1'b0; flush = 1'b1; step(); flush = 1'b0;
    n_tests++;
    if (s_fd !== 1'b0 || s_we !== 1'b1) begin n_fail++; $display("FAIL flush_t2: got fd %b we %b want 0 1", s_fd, s_we); end
    step();
    n_tests++;
    if (s_fd !== 1'b0 || s_we !== 1'b1 || s_busy !== 1'b1) begin
      n_fail++; $display("FAIL flush_t3: got fd %b we %b busy %b want 0 1 1", s_fd, s_we, s_busy);
    end
    step();
    n_tests++;
    if (s_fd !== 1'b1 || s_we !== 1'b0) begin n_fail++; $display("FAIL flush_done: got fd %b we %b want 1 0", s_fd, s_we); end
    step();
    n_tests++;
    if (s_busy !== 1'b0 || s_fd !== 1'b0 || s_cnt !== exp_cnt[15:0]) begin
      n_fail++; $display("FAIL flush_idle: got busy %b fd %b cnt %0d want 0 0 %0d", s_busy, s_fd, s_cnt, exp_cnt);
    end
    flush = 1'b1; step(); flush = 1'b0;
    step();
    n_tests++;
    if (s_fd !== 1'b1 || s_busy !== 1'b0) begin n_fail++; $display("FAIL flush_in_idle: got fd %b busy %b want 1 0", s_fd, s_busy); end
    start_core_img = 1'b1; step(); start_core_img = 1'b0; exp_cnt = 0;
    step();
    n_tests++;
    if (s_cnt !== 16'd0 || s_busy !== 1'b1) begin
      n_fail++; $display("FAIL restart: got cnt %0d busy %b want 0 1", s_cnt, s_busy);
    end
  endtask

  task automatic test_reset_inflight();
    poke(52, 1);
    issue_upd(52, 3); step(); bus.upd_req = 1'b0;
    repeat (3) step();
    n_tests++;
    if (s_cnt !== 16'd1) begin n_fail++; $display("FAIL pre_reset_count: got %0d want 1", s_cnt); end
    bus.upd_req = 1'b1; bus.upd_addr = 10'd50; bus.upd_delta = 24'd7; step();
    bus.upd_addr = 10'd51; rst = 1'b1; step();
    bus.upd_req = 1'b0; rst = 1'b0; step();
    n_tests++;
    if ({s_rd_gnt, s_upd_gnt, s_rd_valid, s_we, s_fd, s_busy} !== 6'b0 ||
        s_rd_data !== '0 || s_addr_r !== '0 || s_addr_w !== '0 || s_data_w !== '0 || s_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_inflight: got ctrl %b cnt %0d addr_w %0d data_w %0h want all 0",
                         {s_rd_gnt, s_upd_gnt, s_rd_valid, s_we, s_fd, s_busy}, s_cnt, s_addr_w, s_data_w);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (s_we !== 1'b0) begin n_fail++; $display("FAIL reset_no_we%0d: got %b want 0", i, s_we); end
    end
  endtask

  initial begin
    rst = 1'b1; start_core_img = 1'b0; flush = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.upd_req = 1'b0; bus.upd_addr = '0; bus.upd_delta = '0;
    test_reset();
    test_read();
    test_update();
    test_saturation();
    test_hazard();
    test_starvation();
    test_flush();
    test_reset_inflight();
    n_tests++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got %0d/%0d pending want 0/0", exp_rd.size(), exp_wr.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
